// File: rtl/div.sv
// div: unsigned restoring shift-subtract divider, one quotient bit per clock,
// MSB first. A division by a non-zero divisor takes exactly WIDTH cycles from
// the accepted start edge to the done edge. A zero divisor completes on the
// start edge itself with quotient = all ones and remainder = dividend.
//
// Ports
//   clock        rising-edge clock for all state
//   reset_n      asynchronous active-low reset
//   start        request, sampled only while busy = 0
//   dividend     unsigned dividend, sampled with start
//   divisor      unsigned divisor, sampled with start
//   quotient     registered quotient, held between done pulses
//   remainder    registered remainder, held between done pulses
//   busy         high while a division is in progress
//   done         one-cycle pulse marking new valid results
//   div_by_zero  registered flag qualifying the last result
//
// state | meaning
// IDLE  | waiting for start; results hold
// RUN   | one quotient bit produced per clock, counter counts down to 0

module div #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RUN  = 1'b1;

  logic             state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   prem_q, prem_d;   // partial remainder, WIDTH+1 bits
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             ge;

  // The partial remainder entering each step is always < divisor, so the
  // shifted value fits in WIDTH+1 bits and the top bit drops out of the shift.
  always_comb begin
    shifted = (prem_q << 1) | {{WIDTH{1'b0}}, dvd_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = (shifted >= {1'b0, dvs_q});
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d  = '1;
            rem_d  = dividend;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            prem_d  = '0;
            cnt_d   = CNT_LOAD;
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        prem_d = ge ? diff : shifted;
        dvd_d  = {dvd_q[WIDTH-2:0], ge};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          quo_d   = dvd_d;
          rem_d   = prem_d[WIDTH-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign busy        = (state_q == S_RUN);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div.sv
module tb_div;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int n_vec;
  int n_err;

  div #(.WIDTH(8)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called #1 after an active edge. Returns #1 after the done edge (or after
  // the budget expires, with lat = -1). Inputs are scrambled after the start
  // edge so any late sampling would corrupt the result.
  task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic z, output int lat, output logic busy_seen);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock); #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    busy_seen = busy;
    lat = -1;
    if (done) lat = 0;
    else begin
      for (int c = 1; c <= 20; c++) begin
        @(posedge clock); #1;
        if (done) begin
          lat = c;
          break;
        end
      end
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic check_div(input string tag, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] q, r, eq, er;
    logic       z, bs;
    int         lat;
    run_div(a, b, q, r, z, lat, bs);
    if (b == 8'd0) begin
      eq = 8'hFF;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
    chk({tag, " quotient"}, 32'(q), 32'(eq));
    chk({tag, " remainder"}, 32'(r), 32'(er));
    chk({tag, " div_by_zero"}, 32'(z), 32'(b == 8'd0));
    chk({tag, " latency"}, 32'(lat), (b == 8'd0) ? 32'd0 : 32'd8);
    chk({tag, " busy after start"}, 32'(bs), 32'(b != 8'd0));
  endtask

  vec_t vecs[14];

  initial begin
    logic [7:0] q, r, a, b;
    logic       z, bs;
    int         lat;
    logic       done_seen;

    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0};
    vecs[1]  = '{8'd255, 8'd1,   8'd255, 8'd0,   1'b0};
    vecs[2]  = '{8'd5,   8'd9,   8'd0,   8'd5,   1'b0};
    vecs[3]  = '{8'd37,  8'd0,   8'd255, 8'd37,  1'b1};
    vecs[4]  = '{8'd200, 8'd3,   8'd66,  8'd2,   1'b0};
    vecs[5]  = '{8'd0,   8'd5,   8'd0,   8'd0,   1'b0};
    vecs[6]  = '{8'd255, 8'd255, 8'd1,   8'd0,   1'b0};
    vecs[7]  = '{8'd254, 8'd255, 8'd0,   8'd254, 1'b0};
    vecs[8]  = '{8'd1,   8'd1,   8'd1,   8'd0,   1'b0};
    vecs[9]  = '{8'd0,   8'd0,   8'd255, 8'd0,   1'b1};
    vecs[10] = '{8'd128, 8'd2,   8'd64,  8'd0,   1'b0};
    vecs[11] = '{8'd255, 8'd16,  8'd15,  8'd15,  1'b0};
    vecs[12] = '{8'd17,  8'd4,   8'd4,   8'd1,   1'b0};
    vecs[13] = '{8'd200, 8'd13,  8'd15,  8'd5,   1'b0};

    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    reset_n  = 1'b0;
    #12;
    chk("reset quotient", 32'(quotient), 32'd0);
    chk("reset remainder", 32'(remainder), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Table: each division starts right after the previous done (no idle gap).
    foreach (vecs[i]) begin
      run_div(vecs[i].a, vecs[i].b, q, r, z, lat, bs);
      chk($sformatf("vec%0d quotient", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("vec%0d remainder", i), 32'(r), 32'(vecs[i].r));
      chk($sformatf("vec%0d div_by_zero", i), 32'(z), 32'(vecs[i].z));
      chk($sformatf("vec%0d latency", i), 32'(lat), vecs[i].z ? 32'd0 : 32'd8);
      chk($sformatf("vec%0d busy after start", i), 32'(bs), 32'(!vecs[i].z));
    end

    // done is a single-cycle pulse
    @(posedge clock); #1;
    chk("done pulse width", 32'(done), 32'd0);
    chk("held quotient idle", 32'(quotient), 32'd15);

    // Back-to-back: 255/1 then 5/9 started in the done cycle
    run_div(8'd255, 8'd1, q, r, z, lat, bs);
    chk("b2b first quotient", 32'(q), 32'd255);
    chk("b2b first remainder", 32'(r), 32'd0);
    start = 1'b1; dividend = 8'd5; divisor = 8'd9;
    @(posedge clock); #1;
    start = 1'b0;
    chk("b2b second accepted busy", 32'(busy), 32'd1);
    chk("b2b done drops", 32'(done), 32'd0);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 4) begin
        chk("b2b quotient held in run", 32'(quotient), 32'd255);
        chk("b2b remainder held in run", 32'(remainder), 32'd0);
      end
      @(posedge clock); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    chk("b2b second latency", 32'(lat), 32'd8);
    chk("b2b second quotient", 32'(quotient), 32'd0);
    chk("b2b second remainder", 32'(remainder), 32'd5);
    @(posedge clock); #1;

    // start while busy is ignored: 200/3 with a 9/9 pulse at cycle 3
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(posedge clock); #1;
    start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd9;
      end
      @(posedge clock); #1;
      start = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
    end
    chk("ignored start latency", 32'(lat), 32'd8);
    chk("ignored start quotient", 32'(quotient), 32'd66);
    chk("ignored start remainder", 32'(remainder), 32'd2);
    @(posedge clock); #1;
    chk("ignored start no extra done", 32'(done), 32'd0);
    chk("ignored start idle", 32'(busy), 32'd0);

    // Reset mid-run aborts with no done
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset quotient", 32'(quotient), 32'd0);
    chk("async reset remainder", 32'(remainder), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset done", 32'(done), 32'd0);
    chk("async reset div_by_zero", 32'(div_by_zero), 32'd0);
    done_seen = 1'b0;
    repeat (6) begin
      @(posedge clock); #1;
      if (done) done_seen = 1'b1;
    end
    chk("no done during reset", 32'(done_seen), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_div("post reset 200/3", 8'd200, 8'd3);

    // Sweep with corner-biased operands against a / and % model
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: a = 8'd0;
        1: a = 8'd255;
        default: a = 8'($urandom_range(0, 255));
      endcase
      case ($urandom_range(0, 4))
        0: b = 8'd0;
        1: b = 8'd1;
        2: b = 8'd255;
        default: b = 8'($urandom_range(0, 255));
      endcase
      check_div($sformatf("sweep %0d/%0d", a, b), a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
